// File: rtl/force_chan_bank_pkg.sv
// rtl/force_chan_bank_pkg.sv - shared types, constants and helpers for force_chan_bank
package force_chan_bank_pkg;

   // Override target: channel output only, or the channel register itself
   typedef enum logic {
      FT_OUT = 1'b0,
      FT_REG = 1'b1
   } force_target_e;

   localparam int DEF_CNTW = 8;

   // Channel index width, never narrower than one bit
   function automatic int chan_idx_w(input int n);
      int w;
      w = $clog2(n);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/force_chan_bank_if.sv
// rtl/force_chan_bank_if.sv - load/force/release command bus and visible state of force_chan_bank
interface force_chan_bank_if
   import force_chan_bank_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int NCHAN = 4,
   parameter int CNTW  = DEF_CNTW,
   parameter int CHW   = chan_idx_w(NCHAN)
);
   logic [NCHAN-1:0]       in_vld;
   logic [NCHAN*WIDTH-1:0] in_data;
   logic                   force_req;
   logic [CHW-1:0]         force_chan;
   logic [WIDTH-1:0]       force_val;
   logic [CNTW-1:0]        force_cycles;
   logic                   release_req;
   logic [CHW-1:0]         release_chan;
   logic [NCHAN*WIDTH-1:0] out;
   logic [NCHAN*WIDTH-1:0] r;
   logic [NCHAN-1:0]       forced;

   modport master (
      output in_vld, in_data, force_req, force_chan, force_val, force_cycles,
      output release_req, release_chan,
      input  out, r, forced
   );

   modport slave (
      input  in_vld, in_data, force_req, force_chan, force_val, force_cycles,
      input  release_req, release_chan,
      output out, r, forced
   );
endinterface

// File: rtl/force_chan_bank_force_chan.sv
// rtl/force_chan_bank_force_chan.sv - one channel: register, override value, force flag, output mux
// FORCE_CHAN_BANK_TIMED_EN builds the per-channel auto-release counter.
module force_chan
   import force_chan_bank_pkg::*;
#(
   parameter int               WIDTH        = 4,
   parameter logic [WIDTH-1:0] RESET_VAL    = WIDTH'(1),
   parameter force_target_e    FORCE_TARGET = FT_OUT,
   parameter int               CNTW         = DEF_CNTW
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_vld,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_force,
   input  logic [WIDTH-1:0] i_force_val,
   input  logic [CNTW-1:0]  i_force_cycles,
   input  logic             i_release,
   output logic [WIDTH-1:0] o_out,
   output logic [WIDTH-1:0] o_r,
   output logic             o_forced
);

   logic [WIDTH-1:0] r_r;
   logic [WIDTH-1:0] r_fval;
   logic             r_forced;
   logic             w_expire;

`ifdef FORCE_CHAN_BANK_TIMED_EN
   logic [CNTW-1:0] r_cnt;

   // Countdown: loaded by a force, cleared by release, steps only while forced
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_cnt <= '0;
      end else if (i_force) begin
         r_cnt <= i_force_cycles;
      end else if (i_release) begin
         r_cnt <= '0;
      end else if (r_forced && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   // A count of 1 on a forced channel means this edge is the last forced one
   assign w_expire = r_forced && (r_cnt == CNTW'(1));
`else
   logic w_unused_cycles;
   assign w_unused_cycles = ^i_force_cycles;
   assign w_expire        = 1'b0;
`endif

   // Force flag and override value; force beats release on the same edge
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_fval   <= '0;
         r_forced <= 1'b0;
      end else if (i_force) begin
         r_fval   <= i_force_val;
         r_forced <= 1'b1;
      end else if (i_release || w_expire) begin
         r_forced <= 1'b0;
      end
   end

   // Channel register; in register-target mode the override owns it while forced
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_r <= RESET_VAL;
      end else if ((FORCE_TARGET == FT_REG) && i_force) begin
         r_r <= i_force_val;
      end else if ((FORCE_TARGET == FT_REG) && r_forced) begin
         r_r <= r_fval;
      end else if (i_vld) begin
         r_r <= i_data;
      end
   end

   assign o_out    = ((FORCE_TARGET == FT_OUT) && r_forced) ? r_fval : r_r;
   assign o_r      = r_r;
   assign o_forced = r_forced;

endmodule

// File: rtl/force_chan_bank.sv
// rtl/force_chan_bank.sv - bank of NCHAN registered channels with force/release override
// FORCE_CHAN_BANK_TIMED_EN enables timed auto-release inside each channel.
module force_chan_bank
   import force_chan_bank_pkg::*;
#(
   parameter int               WIDTH        = 4,
   parameter int               NCHAN        = 4,
   parameter logic [WIDTH-1:0] RESET_VAL    = WIDTH'(1),
   parameter force_target_e    FORCE_TARGET = FT_OUT,
   parameter int               CNTW         = DEF_CNTW,
   parameter int               CHW          = chan_idx_w(NCHAN)
) (
   input logic              i_clk,
   input logic              i_reset,
   force_chan_bank_if.slave bus_if
);

   logic [NCHAN-1:0]       w_force_hit;
   logic [NCHAN-1:0]       w_release_hit;
   logic [NCHAN*WIDTH-1:0] w_out;
   logic [NCHAN*WIDTH-1:0] w_r;
   logic [NCHAN-1:0]       w_forced;

   // Out-of-range channel indices match no channel, so such commands fall away
   for (genvar g = 0; g < NCHAN; g++) begin : g_chan
      assign w_force_hit[g]   = bus_if.force_req   && (bus_if.force_chan   == CHW'(g));
      assign w_release_hit[g] = bus_if.release_req && (bus_if.release_chan == CHW'(g));

      force_chan #(
         .WIDTH        (WIDTH),
         .RESET_VAL    (RESET_VAL),
         .FORCE_TARGET (FORCE_TARGET),
         .CNTW         (CNTW)
      ) u_chan (
         .i_clk          (i_clk),
         .i_reset        (i_reset),
         .i_vld          (bus_if.in_vld[g]),
         .i_data         (bus_if.in_data[g*WIDTH +: WIDTH]),
         .i_force        (w_force_hit[g]),
         .i_force_val    (bus_if.force_val),
         .i_force_cycles (bus_if.force_cycles),
         .i_release      (w_release_hit[g]),
         .o_out          (w_out[g*WIDTH +: WIDTH]),
         .o_r            (w_r[g*WIDTH +: WIDTH]),
         .o_forced       (w_forced[g])
      );
   end

   assign bus_if.out    = w_out;
   assign bus_if.r      = w_r;
   assign bus_if.forced = w_forced;

endmodule

// File: tb/tb_force_chan_bank.sv
// tb/tb_force_chan_bank.sv - scoreboard bench for force_chan_bank (output, register and 3-channel instances)
module tb_force_chan_bank;
   import force_chan_bank_pkg::*;

`ifdef FORCE_CHAN_BANK_TIMED_EN
   localparam bit TIMED = 1'b1;
`else
   localparam bit TIMED = 1'b0;
`endif

   typedef struct {
      logic [3:0]  vld;
      logic [15:0] data;
      logic        freq;
      logic [1:0]  fch;
      logic [3:0]  fval;
      logic [7:0]  fcyc;
      logic        rreq;
      logic [1:0]  rch;
   } stim_t;

   typedef struct {
      logic [15:0] o;
      logic [15:0] r;
      logic [3:0]  f;
   } exp_t;

   logic clk;
   logic i_reset;
   int   n_tests;
   int   n_fail;
   exp_t sb[$];

   force_chan_bank_if #(.WIDTH(4), .NCHAN(4), .CNTW(8), .CHW(2)) bus0 ();
   force_chan_bank_if #(.WIDTH(4), .NCHAN(4), .CNTW(8), .CHW(2)) bus1 ();
   force_chan_bank_if #(.WIDTH(4), .NCHAN(3), .CNTW(8), .CHW(2)) bus2 ();

   force_chan_bank #(.WIDTH(4), .NCHAN(4), .RESET_VAL(4'h1), .FORCE_TARGET(FT_OUT), .CNTW(8), .CHW(2))
      u_dut0 (.i_clk(clk), .i_reset(i_reset), .bus_if(bus0.slave));
   force_chan_bank #(.WIDTH(4), .NCHAN(4), .RESET_VAL(4'h1), .FORCE_TARGET(FT_REG), .CNTW(8), .CHW(2))
      u_dut1 (.i_clk(clk), .i_reset(i_reset), .bus_if(bus1.slave));
   force_chan_bank #(.WIDTH(4), .NCHAN(3), .RESET_VAL(4'h1), .FORCE_TARGET(FT_OUT), .CNTW(8), .CHW(2))
      u_dut2 (.i_clk(clk), .i_reset(i_reset), .bus_if(bus2.slave));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic stim_t mk_stim(input logic [3:0] vld, input logic [15:0] data,
                                     input logic freq, input logic [1:0] fch, input logic [3:0] fval,
                                     input logic [7:0] fcyc, input logic rreq, input logic [1:0] rch);
      stim_t s;
      s.vld = vld; s.data = data; s.freq = freq; s.fch = fch;
      s.fval = fval; s.fcyc = fcyc; s.rreq = rreq; s.rch = rch;
      return s;
   endfunction

   function automatic exp_t mk_exp(input logic [15:0] o, input logic [15:0] r, input logic [3:0] f);
      exp_t e;
      e.o = o; e.r = r; e.f = f;
      return e;
   endfunction

   task automatic drive0(input stim_t s);
      bus0.in_vld = s.vld; bus0.in_data = s.data; bus0.force_req = s.freq; bus0.force_chan = s.fch;
      bus0.force_val = s.fval; bus0.force_cycles = s.fcyc; bus0.release_req = s.rreq; bus0.release_chan = s.rch;
   endtask

   task automatic drive1(input stim_t s);
      bus1.in_vld = s.vld; bus1.in_data = s.data; bus1.force_req = s.freq; bus1.force_chan = s.fch;
      bus1.force_val = s.fval; bus1.force_cycles = s.fcyc; bus1.release_req = s.rreq; bus1.release_chan = s.rch;
   endtask

   task automatic drive2(input stim_t s);
      bus2.in_vld = s.vld[2:0]; bus2.in_data = s.data[11:0]; bus2.force_req = s.freq; bus2.force_chan = s.fch;
      bus2.force_val = s.fval; bus2.force_cycles = s.fcyc; bus2.release_req = s.rreq; bus2.release_chan = s.rch;
   endtask

   task automatic test_reset();
      exp_t e;
      drive0(mk_stim(0, 0, 0, 0, 0, 0, 0, 0));
      drive1(mk_stim(0, 0, 0, 0, 0, 0, 0, 0));
      drive2(mk_stim(0, 0, 0, 0, 0, 0, 0, 0));
      i_reset = 1'b1;
      sb.push_back(mk_exp(16'h1111, 16'h1111, 4'b0000));
      sb.push_back(mk_exp(16'h1111, 16'h1111, 4'b0000));
      sb.push_back(mk_exp(16'h0111, 16'h0111, 4'b0000));
      repeat (2) @(posedge clk);
      #1;
      e = sb.pop_front(); n_tests++;
      if ({bus0.out, bus0.r, bus0.forced} !== {e.o, e.r, e.f}) begin
         n_fail++;
         $display("FAIL reset dut0: got out=%h r=%h forced=%b, want out=%h r=%h forced=%b", bus0.out, bus0.r, bus0.forced, e.o, e.r, e.f);
      end
      e = sb.pop_front(); n_tests++;
      if ({bus1.out, bus1.r, bus1.forced} !== {e.o, e.r, e.f}) begin
         n_fail++;
         $display("FAIL reset dut1: got out=%h r=%h forced=%b, want out=%h r=%h forced=%b", bus1.out, bus1.r, bus1.forced, e.o, e.r, e.f);
      end
      e = sb.pop_front(); n_tests++;
      if ({bus2.out, bus2.r, bus2.forced} !== {e.o[11:0], e.r[11:0], e.f[2:0]}) begin
         n_fail++;
         $display("FAIL reset dut2: got out=%h r=%h forced=%b, want out=%h r=%h forced=%b", bus2.out, bus2.r, bus2.forced, e.o[11:0], e.r[11:0], e.f[2:0]);
      end
      i_reset = 1'b0;
   endtask

   task automatic run0(input string name, input stim_t st[$], input exp_t ex[$]);
      exp_t e;
      for (int k = 0; k < st.size(); k++) begin
         drive0(st[k]);
         sb.push_back(ex[k]);
         @(posedge clk);
         #1;
         e = sb.pop_front(); n_tests++;
         if ({bus0.out, bus0.r, bus0.forced} !== {e.o, e.r, e.f}) begin
            n_fail++;
            $display("FAIL %s step %0d: got out=%h r=%h forced=%b, want out=%h r=%h forced=%b", name, k, bus0.out, bus0.r, bus0.forced, e.o, e.r, e.f);
         end
      end
      drive0(mk_stim(0, 0, 0, 0, 0, 0, 0, 0));
   endtask

   task automatic test_load();
      run0("load",
         '{mk_stim(4'b1001, 16'hA001, 0, 0, 0, 0, 0, 0),
           mk_stim(4'b0100, 16'h0600, 0, 0, 0, 0, 0, 0)},
         '{mk_exp(16'hA111, 16'hA111, 4'b0000),
           mk_exp(16'hA611, 16'hA611, 4'b0000)});
   endtask

   task automatic test_force_out();
      run0("force_out",
         '{mk_stim(0,       0,        1, 1, 4'h3, 0, 0, 0),
           mk_stim(4'b0010, 16'h0050, 0, 0, 0,    0, 0, 0),
           mk_stim(0,       0,        0, 0, 0,    0, 0, 0),
           mk_stim(0,       0,        0, 0, 0,    0, 1, 1),
           mk_stim(0,       0,        0, 0, 0,    0, 1, 3)},
         '{mk_exp(16'hA631, 16'hA611, 4'b0010),
           mk_exp(16'hA631, 16'hA651, 4'b0010),
           mk_exp(16'hA631, 16'hA651, 4'b0010),
           mk_exp(16'hA651, 16'hA651, 4'b0000),
           mk_exp(16'hA651, 16'hA651, 4'b0000)});
   endtask

   task automatic test_force_reg();
      stim_t st[8];
      exp_t  ex[8];
      exp_t  e;
      st = '{mk_stim(0,       0,        1, 2, 4'h2, 0, 0, 0),
             mk_stim(4'b0100, 16'h0700, 0, 0, 0,    0, 0, 0),
             mk_stim(0,       0,        0, 0, 0,    0, 1, 2),
             mk_stim(0,       0,        0, 0, 0,    0, 0, 0),
             mk_stim(0,       0,        0, 0, 0,    0, 0, 0),
             mk_stim(4'b0100, 16'h0900, 0, 0, 0,    0, 0, 0),
             mk_stim(4'b0001, 16'h0004, 1, 0, 4'hB, 0, 0, 0),
             mk_stim(0,       0,        0, 0, 0,    0, 1, 0)};
      ex = '{mk_exp(16'h1211, 16'h1211, 4'b0100),
             mk_exp(16'h1211, 16'h1211, 4'b0100),
             mk_exp(16'h1211, 16'h1211, 4'b0000),
             mk_exp(16'h1211, 16'h1211, 4'b0000),
             mk_exp(16'h1211, 16'h1211, 4'b0000),
             mk_exp(16'h1911, 16'h1911, 4'b0000),
             mk_exp(16'h191B, 16'h191B, 4'b0001),
             mk_exp(16'h191B, 16'h191B, 4'b0000)};
      for (int k = 0; k < 8; k++) begin
         drive1(st[k]);
         sb.push_back(ex[k]);
         @(posedge clk);
         #1;
         e = sb.pop_front(); n_tests++;
         if ({bus1.out, bus1.r, bus1.forced} !== {e.o, e.r, e.f}) begin
            n_fail++;
            $display("FAIL force_reg step %0d: got out=%h r=%h forced=%b, want out=%h r=%h forced=%b", k, bus1.out, bus1.r, bus1.forced, e.o, e.r, e.f);
         end
      end
      drive1(mk_stim(0, 0, 0, 0, 0, 0, 0, 0));
   endtask

   task automatic test_timed();
      exp_t on_e, off_e, end_e;
      on_e  = mk_exp(16'hA65F, 16'hA651, 4'b0001);
      off_e = mk_exp(16'hA651, 16'hA651, 4'b0000);
      end_e = TIMED ? off_e : on_e;
      run0("timed",
         '{mk_stim(0, 0, 1, 0, 4'hF, 8'd3, 0, 0),
           mk_stim(0, 0, 0, 0, 0,    0,    0, 0),
           mk_stim(0, 0, 0, 0, 0,    0,    0, 0),
           mk_stim(0, 0, 0, 0, 0,    0,    0, 0),
           mk_stim(0, 0, 0, 0, 0,    0,    1, 0),
           mk_stim(0, 0, 1, 0, 4'hF, 8'd3, 0, 0),
           mk_stim(0, 0, 0, 0, 0,    0,    0, 0),
           mk_stim(0, 0, 1, 0, 4'hF, 8'd3, 0, 0),
           mk_stim(0, 0, 0, 0, 0,    0,    0, 0),
           mk_stim(0, 0, 0, 0, 0,    0,    0, 0),
           mk_stim(0, 0, 0, 0, 0,    0,    0, 0),
           mk_stim(0, 0, 0, 0, 0,    0,    1, 0)},
         '{on_e, on_e, on_e, end_e, off_e,
           on_e, on_e, on_e, on_e, on_e, end_e, off_e});
   endtask

   task automatic test_same_cycle();
      run0("same_cycle",
         '{mk_stim(0,       0,        1, 2, 4'h8, 0, 1, 2),
           mk_stim(0,       0,        1, 3, 4'hC, 0, 1, 2),
           mk_stim(0,       0,        0, 0, 0,    0, 1, 3),
           mk_stim(4'b0010, 16'h0020, 1, 1, 4'hE, 0, 0, 0),
           mk_stim(0,       0,        0, 0, 0,    0, 1, 1)},
         '{mk_exp(16'hA851, 16'hA651, 4'b0100),
           mk_exp(16'hC651, 16'hA651, 4'b1000),
           mk_exp(16'hA651, 16'hA651, 4'b0000),
           mk_exp(16'hA6E1, 16'hA621, 4'b0010),
           mk_exp(16'hA621, 16'hA621, 4'b0000)});
   endtask

   task automatic test_bad_chan();
      stim_t st[5];
      exp_t  ex[5];
      exp_t  e;
      st = '{mk_stim(4'b0111, 16'h0345, 0, 0, 0,    0, 0, 0),
             mk_stim(0,       0,        1, 3, 4'hF, 0, 0, 0),
             mk_stim(0,       0,        1, 1, 4'hE, 0, 0, 0),
             mk_stim(0,       0,        0, 0, 0,    0, 1, 3),
             mk_stim(0,       0,        0, 0, 0,    0, 1, 1)};
      ex = '{mk_exp(16'h0345, 16'h0345, 4'b000),
             mk_exp(16'h0345, 16'h0345, 4'b000),
             mk_exp(16'h03E5, 16'h0345, 4'b010),
             mk_exp(16'h03E5, 16'h0345, 4'b010),
             mk_exp(16'h0345, 16'h0345, 4'b000)};
      for (int k = 0; k < 5; k++) begin
         drive2(st[k]);
         sb.push_back(ex[k]);
         @(posedge clk);
         #1;
         e = sb.pop_front(); n_tests++;
         if ({bus2.out, bus2.r, bus2.forced} !== {e.o[11:0], e.r[11:0], e.f[2:0]}) begin
            n_fail++;
            $display("FAIL bad_chan step %0d: got out=%h r=%h forced=%b, want out=%h r=%h forced=%b", k, bus2.out, bus2.r, bus2.forced, e.o[11:0], e.r[11:0], e.f[2:0]);
         end
      end
      drive2(mk_stim(0, 0, 0, 0, 0, 0, 0, 0));
   endtask

   task automatic test_back_to_back();
      logic [11:0] m;
      logic [2:0]  v;
      logic [11:0] d;
      exp_t        e;
      m = 12'h345;
      for (int k = 0; k < 8; k++) begin
         v = 3'($urandom_range(1, 7));
         d = 12'($urandom);
         for (int c = 0; c < 3; c++) begin
            if (v[c]) m[c*4 +: 4] = d[c*4 +: 4];
         end
         drive2(mk_stim({1'b0, v}, {4'h0, d}, 0, 0, 0, 0, 0, 0));
         sb.push_back(mk_exp({4'h0, m}, {4'h0, m}, 4'b0000));
         @(posedge clk);
         #1;
         e = sb.pop_front(); n_tests++;
         if ({bus2.out, bus2.r, bus2.forced} !== {e.o[11:0], e.r[11:0], e.f[2:0]}) begin
            n_fail++;
            $display("FAIL back_to_back step %0d: got out=%h r=%h forced=%b, want out=%h r=%h forced=%b", k, bus2.out, bus2.r, bus2.forced, e.o[11:0], e.r[11:0], e.f[2:0]);
         end
      end
      drive2(mk_stim(0, 0, 0, 0, 0, 0, 0, 0));
   endtask

   task automatic test_reset_mid_force();
      exp_t e;
      drive0(mk_stim(0, 0, 1, 0, 4'h7, 0, 0, 0));
      drive1(mk_stim(0, 0, 1, 3, 4'h6, 0, 0, 0));
      sb.push_back(mk_exp(16'hA627, 16'hA621, 4'b0001));
      sb.push_back(mk_exp(16'h691B, 16'h691B, 4'b1000));
      @(posedge clk);
      #1;
      e = sb.pop_front(); n_tests++;
      if ({bus0.out, bus0.r, bus0.forced} !== {e.o, e.r, e.f}) begin
         n_fail++;
         $display("FAIL pre_reset dut0: got out=%h r=%h forced=%b, want out=%h r=%h forced=%b", bus0.out, bus0.r, bus0.forced, e.o, e.r, e.f);
      end
      e = sb.pop_front(); n_tests++;
      if ({bus1.out, bus1.r, bus1.forced} !== {e.o, e.r, e.f}) begin
         n_fail++;
         $display("FAIL pre_reset dut1: got out=%h r=%h forced=%b, want out=%h r=%h forced=%b", bus1.out, bus1.r, bus1.forced, e.o, e.r, e.f);
      end
      i_reset = 1'b1;
      drive0(mk_stim(4'b1111, 16'hFFFF, 1, 2, 4'h9, 0, 0, 0));
      drive1(mk_stim(0, 0, 0, 0, 0, 0, 0, 0));
      drive2(mk_stim(4'b0111, 16'h0FFF, 1, 0, 4'h9, 0, 0, 0));
      sb.push_back(mk_exp(16'h1111, 16'h1111, 4'b0000));
      sb.push_back(mk_exp(16'h1111, 16'h1111, 4'b0000));
      sb.push_back(mk_exp(16'h0111, 16'h0111, 4'b0000));
      @(posedge clk);
      #1;
      e = sb.pop_front(); n_tests++;
      if ({bus0.out, bus0.r, bus0.forced} !== {e.o, e.r, e.f}) begin
         n_fail++;
         $display("FAIL mid_reset dut0: got out=%h r=%h forced=%b, want out=%h r=%h forced=%b", bus0.out, bus0.r, bus0.forced, e.o, e.r, e.f);
      end
      e = sb.pop_front(); n_tests++;
      if ({bus1.out, bus1.r, bus1.forced} !== {e.o, e.r, e.f}) begin
         n_fail++;
         $display("FAIL mid_reset dut1: got out=%h r=%h forced=%b, want out=%h r=%h forced=%b", bus1.out, bus1.r, bus1.forced, e.o, e.r, e.f);
      end
      e = sb.pop_front(); n_tests++;
      if ({bus2.out, bus2.r, bus2.forced} !== {e.o[11:0], e.r[11:0], e.f[2:0]}) begin
         n_fail++;
         $display("FAIL mid_reset dut2: got out=%h r=%h forced=%b, want out=%h r=%h forced=%b", bus2.out, bus2.r, bus2.forced, e.o[11:0], e.r[11:0], e.f[2:0]);
      end
      i_reset = 1'b0;
      drive0(mk_stim(0, 0, 0, 0, 0, 0, 0, 0));
      drive2(mk_stim(0, 0, 0, 0, 0, 0, 0, 0));
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      i_reset = 1'b1;
      @(negedge clk);
      test_reset();
      test_load();
      test_force_out();
      test_force_reg();
      test_timed();
      test_same_cycle();
      test_bad_chan();
      test_back_to_back();
      test_reset_mid_force();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/force_chan_bank.md
# force_chan_bank

Parametrised bank of NCHAN registered channels, each WIDTH bits, with per-channel force/release override and optional timed auto-release. Generalises the single 4-bit registered-output block to many channels with hardware-controlled override. Two override targets are supported: the channel output only, or the channel register itself. The block sits between producer logic and consumers as a debug and fault-injection point.

## Interface
- WIDTH, 4: data bits per channel
- NCHAN, 4: number of channels, ≥1
- RESET_VAL, 4'h1 (WIDTH bits): reset value of every channel register
- FORCE_TARGET, 0: 0 = force output only; 1 = force the channel register
- CNTW, 8: width of the auto-release counter
- CHW, $clog2(NCHAN) (min 1): channel index width
- clk  input  1  clock; all logic on posedge
- reset  input  1  synchronous, active-high reset
- in_vld  input  NCHAN  per-channel load strobe
- in_data  input  NCHAN*WIDTH  load data; channel i at [i*WIDTH +: WIDTH]
- force_req  input  1  force command strobe
- force_chan  input  CHW  channel to force
- force_val  input  WIDTH  forced value
- force_cycles  input  CNTW  auto-release length; 0 = until release
- release_req  input  1  release command strobe
- release_chan  input  CHW  channel to release
- out  output  NCHAN*WIDTH  per-channel visible value
- r  output  NCHAN*WIDTH  underlying channel registers
- forced  output  NCHAN  per-channel force-active flag

## Operation
- Load, unforced channel: on in_vld[i], r[i] <= in_data[i]; out[i] = r[i].
- Force on channel c at an edge with force_req:
  - fval[c] <= force_val; forced[c] <= 1; cnt[c] <= force_cycles.
  - A re-force of an already-forced channel overwrites fval and reloads cnt.
- FORCE_TARGET=0: out[c] = fval[c] while forced. r[c] keeps loading from in_vld underneath. On release, out[c] = r[c] immediately.
- FORCE_TARGET=1: while forced, r[c] <= fval[c] each cycle and in_vld[c] is ignored. On release, r[c] retains fval until the next in_vld[c]. out[c] = r[c] always.
- Release: release_req on channel c clears forced[c] and cnt[c]. Releasing an unforced channel is a no-op.
- Simultaneous force_req and release_req:
  - Same channel: force wins.
  - Different channels: both take effect.
- force_chan or release_chan ≥ NCHAN: command ignored.
- in_vld on the channel being forced in the same cycle: the force applies. With FORCE_TARGET=0, r still loads.

## Timing
- Reset: r = RESET_VAL, fval = 0, forced = 0, cnt = 0, out = RESET_VAL on every channel.
- Reset has priority over all commands, including mid-force; forced[] clears on the next edge.
- Load latency is 1 cycle, in_vld edge to r/out.
- Force and release latency is 1 cycle, command edge to out/forced.
- out is combinational from registered state only; there is no input-to-output combinational path.
- Timed release (force_cycles = N > 0): forced stays high for exactly N cycles after the command edge and clears on the Nth following edge. The counter decrements only while forced. A new force_req reloads the counter.

## Configuration
- FORCE_CHAN_BANK_TIMED_EN defined: per-channel CNTW-bit counters are built and timed auto-release works as above.
- FORCE_CHAN_BANK_TIMED_EN undefined: no counters are built. The force_cycles port remains but is ignored. Every force persists until release_req or reset.

## Structure
- Package force_chan_bank_pkg holds:
  - force_target_e enum (FT_OUT=0, FT_REG=1)
  - default CNTW constant
  - chan_idx_w(n) function returning max(1, $clog2(n))
- Sub-module force_chan: one channel's r, fval, forced and cnt state plus the output mux. It is generated NCHAN times; the top decodes force/release commands into per-channel strobes.

## Test plan
- Reset, then load ch0=4'h1 and ch3=4'hA → out = {4'hA, RESET_VAL, RESET_VAL, 4'h1}; forced = 0.
- FORCE_TARGET=0: force ch1=4'h3 with force_cycles=0, load ch1=4'h5, release → out ch1 reads 3 while forced, r ch1 reads 5; after release out ch1 = 5.
- FORCE_TARGET=1: force ch2=4'h2, pulse in_vld ch2=4'h7, release, wait 2 cycles, then in_vld=4'h9 → r ch2 stays 2 through release and becomes 9 only after the load.
- TIMED_EN: force ch0=4'hF with force_cycles=3 → forced[0] high for exactly 3 cycles, then out ch0 = r ch0. Re-force at cycle 2 with 3 → total of 5 cycles high.
- Force and release the same channel in one cycle → forced = 1. force_chan = NCHAN (with NCHAN=3) → no state change.
- Reset asserted mid-force → next cycle forced = 0 and out = RESET_VAL on all channels.
